// File: rtl/hub75_phy_seq_pkg.sv
// Shared op codes, FSM state encoding and sizing helpers for the HUB75 PHY sequencer.
// HUB75_PHY_ADDR_INC_EN adds the INC state used by incrementing-address panels.
package hub75_phy_seq_pkg;

  typedef enum logic [1:0] {
    OP_LATCH = 2'd0,
    OP_ADDR  = 2'd1,
    OP_BLANK = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SH_LO  = 3'd1,
    ST_SH_HI  = 3'd2,
    ST_LATCH  = 3'd3,
    ST_ADDR   = 3'd4,
`ifdef HUB75_PHY_ADDR_INC_EN
    ST_SETTLE = 3'd5,
    ST_INC    = 3'd6
`else
    ST_SETTLE = 3'd5
`endif
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hub75_phy_seq_if.sv
// Column stream and command channel between the scan engine and the HUB75 PHY.
// Handshake: a beat transfers on a rising clk edge where valid && ready; valid is held until then, ready may depend on state.
interface hub75_phy_seq_if #(
  parameter int SDW        = 6,
  parameter int LOG_N_ROWS = 5
);
  logic [SDW-1:0]        sh_data;
  logic                  sh_valid;
  logic                  sh_ready;
  logic [1:0]            cmd_op;
  logic [LOG_N_ROWS-1:0] cmd_arg;
  logic                  cmd_valid;
  logic                  cmd_ready;

  modport master (
    output sh_data, sh_valid, cmd_op, cmd_arg, cmd_valid,
    input  sh_ready, cmd_ready
  );

  modport slave (
    input  sh_data, sh_valid, cmd_op, cmd_arg, cmd_valid,
    output sh_ready, cmd_ready
  );
endinterface

// File: rtl/hub75_phy_oreg.sv
// Final pad register stage; every pad group goes through one of these so all pads share one latency.
module hub75_phy_oreg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/hub75_phy_seq.sv
// HUB75 PHY sequencer: shifts columns with a divided clock, pulses LE, and changes row address under blanking.
// Define HUB75_PHY_ADDR_INC_EN for panels addressed by increment/reset pulses (adds hub75_addr_inc/hub75_addr_rst).
module hub75_phy_seq
  import hub75_phy_seq_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_CHANS     = 3,
  parameter int PHY_N       = 1,
  parameter int CLK_DIV     = 2,
  parameter int LE_W        = 2,
  parameter int ADDR_SETTLE = 4,
  localparam int SDW        = N_BANKS * N_CHANS,
  localparam int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  hub75_phy_seq_if.slave                bus,
  output logic                          busy,
  output state_e                        dbg_state,
  output logic [SDW-1:0]                hub75_data,
  output logic [PHY_N*LOG_N_ROWS-1:0]   hub75_addr,
  output logic [PHY_N-1:0]              hub75_clk,
  output logic [PHY_N-1:0]              hub75_le,
  output logic [PHY_N-1:0]              hub75_blank
`ifdef HUB75_PHY_ADDR_INC_EN
  ,
  output logic [PHY_N-1:0]              hub75_addr_inc,
  output logic [PHY_N-1:0]              hub75_addr_rst
`endif
);

  localparam int TW = $clog2(max3(CLK_DIV, LE_W, ADDR_SETTLE) + 1);
  localparam logic [TW-1:0] HALF_LD   = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] LE_LD     = TW'(LE_W - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(ADDR_SETTLE - 1);

  state_e                state;
  logic [TW-1:0]         cnt;
  logic                  run;
  logic [SDW-1:0]        data_r;
  logic [LOG_N_ROWS-1:0] addr_r;
  logic [LOG_N_ROWS-1:0] tgt;
  logic                  clk_r, le_r, blank_r, blank_lvl;
  logic                  shift_last, sh_acc, cmd_acc;
`ifdef HUB75_PHY_ADDR_INC_EN
  logic                  inc_r, arst_r;
`endif

  // run stays low through reset so neither channel reports ready until the first edge after release.
  assign shift_last    = (state == ST_SH_HI) && (cnt == '0);
  assign bus.sh_ready  = run && ((state == ST_IDLE) || shift_last);
  assign bus.cmd_ready = run && (state == ST_IDLE) && !bus.sh_valid;
  assign sh_acc        = bus.sh_valid && bus.sh_ready;
  assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run       <= 1'b0;
      data_r    <= '0;
      addr_r    <= '0;
      tgt       <= '0;
      clk_r     <= 1'b0;
      le_r      <= 1'b0;
      blank_r   <= 1'b1;
      blank_lvl <= 1'b1;
`ifdef HUB75_PHY_ADDR_INC_EN
      inc_r     <= 1'b0;
      arst_r    <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sh_acc) begin
            data_r <= bus.sh_data;
            cnt    <= HALF_LD;
            state  <= ST_SH_LO;
          end else if (cmd_acc) begin
            case (op_e'(bus.cmd_op))
              OP_LATCH: begin
                le_r  <= 1'b1;
                cnt   <= LE_LD;
                state <= ST_LATCH;
              end
              OP_ADDR: begin
                blank_r <= 1'b1;
                tgt     <= bus.cmd_arg;
                state   <= ST_ADDR;
              end
              OP_BLANK: begin
                blank_lvl <= bus.cmd_arg[0];
                blank_r   <= bus.cmd_arg[0];
              end
              default: ;
            endcase
          end
        end
        ST_SH_LO: begin
          if (cnt == '0) begin
            clk_r <= 1'b1;
            cnt   <= HALF_LD;
            state <= ST_SH_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Last high cycle takes the next column directly so the pad clock has no gap.
        ST_SH_HI: begin
          if (cnt == '0) begin
            clk_r <= 1'b0;
            if (sh_acc) begin
              data_r <= bus.sh_data;
              cnt    <= HALF_LD;
              state  <= ST_SH_LO;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LATCH: begin
          if (cnt == '0) begin
            le_r  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef HUB75_PHY_ADDR_INC_EN
        ST_ADDR: begin
          if (tgt < addr_r) begin
            arst_r <= 1'b1;
            addr_r <= '0;
          end
          state <= ST_INC;
        end
        // Each increment is one high cycle followed by one low cycle before the next compare.
        ST_INC: begin
          arst_r <= 1'b0;
          if (inc_r) begin
            inc_r <= 1'b0;
          end else if (addr_r == tgt) begin
            cnt   <= SETTLE_LD;
            state <= ST_SETTLE;
          end else begin
            inc_r  <= 1'b1;
            addr_r <= addr_r + 1'b1;
          end
        end
`else
        ST_ADDR: begin
          addr_r <= tgt;
          cnt    <= SETTLE_LD;
          state  <= ST_SETTLE;
        end
`endif
        ST_SETTLE: begin
          if (cnt == '0) begin
            blank_r <= blank_lvl;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hub75_phy_oreg #(.WIDTH(SDW), .RESET_VAL('0)) u_data (
    .clk(clk), .rst(rst), .d(data_r), .q(hub75_data));
  hub75_phy_oreg #(.WIDTH(PHY_N*LOG_N_ROWS), .RESET_VAL('0)) u_addr (
    .clk(clk), .rst(rst), .d({PHY_N{addr_r}}), .q(hub75_addr));
  hub75_phy_oreg #(.WIDTH(PHY_N), .RESET_VAL('0)) u_clk (
    .clk(clk), .rst(rst), .d({PHY_N{clk_r}}), .q(hub75_clk));
  hub75_phy_oreg #(.WIDTH(PHY_N), .RESET_VAL('0)) u_le (
    .clk(clk), .rst(rst), .d({PHY_N{le_r}}), .q(hub75_le));
  hub75_phy_oreg #(.WIDTH(PHY_N), .RESET_VAL({PHY_N{1'b1}})) u_blank (
    .clk(clk), .rst(rst), .d({PHY_N{blank_r}}), .q(hub75_blank));
`ifdef HUB75_PHY_ADDR_INC_EN
  hub75_phy_oreg #(.WIDTH(PHY_N), .RESET_VAL('0)) u_inc (
    .clk(clk), .rst(rst), .d({PHY_N{inc_r}}), .q(hub75_addr_inc));
  hub75_phy_oreg #(.WIDTH(PHY_N), .RESET_VAL('0)) u_arst (
    .clk(clk), .rst(rst), .d({PHY_N{arst_r}}), .q(hub75_addr_rst));
`endif

endmodule
